phoneme_sequencer: RTL and testbench
====================================

Name: phoneme_sequencer

Overview:
- Queues phoneme codes written by the 68k bus-register layer and plays them back-to-back on the phoneme speech engine.
- The speech engine accepts one phoneme per start pulse and reports progress on its busy and finish lines.
- Sits between the synthesizer register block (push side) and the speech engine (start/sel side). The CPU can write a whole word without polling busy per phoneme.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- ACK_TIMEOUT, 1024, cycles allowed in WAIT_BUSY for the engine to raise busy after a start pulse.
- GAP_CYCLES, 50000, inter-phoneme silence in cycles; used only when PHONEME_GAP_EN is defined.

Ports:
- Clock  in  1  system clock
- Reset_H  in  1  asynchronous, active-high reset
- push_valid  in  1  enqueue push_data this cycle
- push_data  in  8  phoneme code
- flush  in  1  discard all queued entries
- pause  in  1  hold off launching new phonemes
- clear_flags  in  1  clear the sticky error flags
- phoneme_speech_busy  in  1  engine is playing
- phoneme_speech_finish  in  1  engine has completed a phoneme
- start_phoneme_output  out  1  one-cycle start pulse to the engine
- phoneme_sel  out  8  phoneme code presented to the engine
- fifo_count  out  $clog2(DEPTH)+1  number of queued entries
- fifo_full  out  1  fifo_count == DEPTH
- fifo_empty  out  1  fifo_count == 0
- seq_active  out  1  state machine is not in IDLE
- overflow  out  1  sticky: a push was dropped
- ack_timeout_err  out  1  sticky: engine never acknowledged a start

Behaviour:
- Reset (asynchronous, Reset_H=1):
  - state=IDLE.
  - FIFO pointers and count cleared.
  - All outputs 0, except fifo_empty=1.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - fifo_full and fifo_empty are derived from the registered count.
- Push:
  - Accepted at the clock edge when push_valid=1 and fifo_full=0.
  - push_valid=1 with fifo_full=1 drops the data and sets overflow. This holds even if a pop occurs in the same cycle; fullness is evaluated before the pop.
  - Simultaneous accepted push and pop leave the count unchanged.
- Flush:
  - Empties the FIFO next edge and has priority over a push in the same cycle; that push is dropped and does not set overflow.
  - A phoneme already launched runs to completion. The state machine is unaffected.
- Sticky flags: cleared by clear_flags. A set condition in the same cycle wins over the clear.
- FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP:
  - IDLE: if !fifo_empty && !pause && !flush, pop the head into phoneme_sel and go to LAUNCH.
  - LAUNCH: start_phoneme_output=1 for exactly this cycle (registered). Timer cleared. Go to WAIT_BUSY.
  - WAIT_BUSY: busy=1 goes to WAIT_DONE. Otherwise, when the timer reaches ACK_TIMEOUT-1, set ack_timeout_err and go to the post-phoneme state.
  - WAIT_DONE: finish=1 or busy=0 goes to the post-phoneme state.
  - Post-phoneme state is GAP if PHONEME_GAP_EN is defined, else IDLE.
  - GAP: count GAP_CYCLES, then go to IDLE.
- Latency:
  - A push accepted at edge N into an empty FIFO while IDLE is popped at edge N+1.
  - start_phoneme_output is high from edge N+2 to edge N+3.
  - Back-to-back phonemes without the gap option: the next start pulse is 2 cycles after the WAIT_DONE exit edge.
- phoneme_sel holds its value from pop until the next pop; it is never cleared except by reset.
- pause is sampled only in IDLE. It does not abort a phoneme in flight.
- seq_active=1 in every state except IDLE.
- Reset mid-phoneme returns to IDLE immediately. start_phoneme_output is 0 and the engine is not re-triggered.

Optional Feature:
- Macro: PHONEME_GAP_EN.
- Defined: GAP state and a GAP_CYCLES down-counter are built in, inserting silence after each phoneme.
- Undefined: no GAP state or counter; the post-phoneme state is IDLE.

Decomposition:
- Package phoneme_seq_pkg holds:
  - the state enum seq_state_t;
  - the PHONEME_W=8 constant;
  - the silence phoneme code constants used by software tests.
- One sub-module, phoneme_fifo: parameterized DEPTH x PHONEME_W synchronous FIFO with push, pop, flush, count, full and empty.

Test Plan:
- Reset, then push 0x1A with pause=0 -> start pulse 1 cycle wide, 2 cycles after the push edge. phoneme_sel=0x1A. Engine model raises busy for 20 cycles and pulses finish -> seq_active returns to 0.
- Push 0x05, 0x10, 0x2B back-to-back -> three start pulses in order with phoneme_sel 0x05, 0x10, 0x2B. Each pulse waits for the previous finish. fifo_count sequence is 3, 2, 1, 0.
- Push 17 entries with DEPTH=16 and pause=1 -> fifo_full=1, fifo_count=16, overflow=1. The 17th entry is never played. clear_flags -> overflow=0.
- Engine model never raises busy -> ack_timeout_err=1 exactly ACK_TIMEOUT cycles after WAIT_BUSY entry, then the next queued phoneme launches.
- Queue 4 entries, assert flush during WAIT_DONE of the first -> the first completes, fifo_count=0, no further start pulses.
- With PHONEME_GAP_EN and GAP_CYCLES=10 -> spacing from finish to the next start pulse is 12 cycles. Assert Reset_H mid-gap -> all outputs are at reset values immediately.

Source files
------------

// File: rtl/phoneme_seq_pkg.sv
// phoneme_seq_pkg: shared state type and phoneme constants for the phoneme sequencer
package phoneme_seq_pkg;
    localparam int PHONEME_W = 8;
    localparam logic [PHONEME_W-1:0] PH_PAUSE_SHORT = 8'h00;
    localparam logic [PHONEME_W-1:0] PH_PAUSE_LONG  = 8'h03;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} seq_state_t;
endpackage

// File: rtl/phoneme_fifo.sv
// phoneme_fifo: DEPTH x PHONEME_W circular FIFO with push, pop, flush and registered count
module phoneme_fifo
    import phoneme_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_H,
    input  logic                  push,
    input  logic [PHONEME_W-1:0]  push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [PHONEME_W-1:0]  head,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    logic [PHONEME_W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];
    always_ff @(posedge Clock or posedge Reset_H)
        if (Reset_H) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge Clock)
        if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/phoneme_sequencer.sv
// phoneme_sequencer: queues phoneme codes and plays them back-to-back on the speech engine.
// Define PHONEME_GAP_EN to insert GAP_CYCLES of silence after every phoneme.
module phoneme_sequencer
    import phoneme_seq_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 1024,
    parameter int GAP_CYCLES  = 50000
) (
    input  logic                   Clock,
    input  logic                   Reset_H,
    input  logic                   push_valid,
    input  logic [PHONEME_W-1:0]   push_data,
    input  logic                   flush,
    input  logic                   pause,
    input  logic                   clear_flags,
    input  logic                   phoneme_speech_busy,
    input  logic                   phoneme_speech_finish,
    output logic                   start_phoneme_output,
    output logic [PHONEME_W-1:0]   phoneme_sel,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   seq_active,
    output logic                   overflow,
    output logic                   ack_timeout_err
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    seq_state_t state, state_nx;
    logic [TW-1:0] timer;
    logic [PHONEME_W-1:0] head;
    logic pop, timed_out, ovf_set;
`ifdef PHONEME_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam seq_state_t POST = GAP;
    logic [GW-1:0] gap_cnt;
    always_ff @(posedge Clock or posedge Reset_H)
        if (Reset_H) gap_cnt <= '0;
        else gap_cnt <= state != GAP ? GW'(GAP_CYCLES - 1) : gap_cnt - GW'(1);
`else
    localparam seq_state_t POST = IDLE;
    logic unused_gap;
    assign unused_gap = ^GAP_CYCLES;
`endif
    phoneme_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clock     (Clock),
        .Reset_H   (Reset_H),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
    // fullness is judged before any same-cycle pop, so a push into a full FIFO is always lost
    assign ovf_set    = push_valid && fifo_full && !flush;
    assign timed_out  = state == WAIT_BUSY && !phoneme_speech_busy && timer == TW'(ACK_TIMEOUT - 1);
    assign seq_active = state != IDLE;
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                pop      = !fifo_empty && !pause && !flush;
                state_nx = pop ? LAUNCH : IDLE;
            end
            LAUNCH:    state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = phoneme_speech_busy ? WAIT_DONE : timed_out ? POST : WAIT_BUSY;
            WAIT_DONE: state_nx = (phoneme_speech_finish || !phoneme_speech_busy) ? POST : WAIT_DONE;
`ifdef PHONEME_GAP_EN
            GAP:       state_nx = gap_cnt == '0 ? IDLE : GAP;
`endif
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge Clock or posedge Reset_H)
        if (Reset_H) begin
            state                <= IDLE;
            timer                <= '0;
            start_phoneme_output <= 1'b0;
            phoneme_sel          <= '0;
            overflow             <= 1'b0;
            ack_timeout_err      <= 1'b0;
        end else begin
            state                <= state_nx;
            timer                <= state == WAIT_BUSY ? timer + TW'(1) : '0;
            start_phoneme_output <= state == LAUNCH;
            phoneme_sel          <= pop ? head : phoneme_sel;
            overflow             <= ovf_set || (overflow && !clear_flags);
            ack_timeout_err      <= timed_out || (ack_timeout_err && !clear_flags);
        end
endmodule

// File: tb/tb_phoneme_sequencer.sv
// tb_phoneme_sequencer: self-checking bench with a reference model; covers the gap option when
// built with PHONEME_GAP_EN defined.
module tb_phoneme_sequencer;
    localparam int DEPTH = 16, ACK_TIMEOUT = 32, GAP_CYCLES = 10;
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef PHONEME_GAP_EN
    localparam bit GAPB = 1'b1;
`else
    localparam bit GAPB = 1'b0;
`endif
    localparam logic [18:0] RST_OUT = {1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 3'b000};
    logic Clock = 1'b0;
    logic Reset_H = 1'b1;
    logic push_valid = 1'b0, flush = 1'b0, pause = 1'b0, clear_flags = 1'b0;
    logic phoneme_speech_busy = 1'b0, phoneme_speech_finish = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic start_phoneme_output, fifo_full, fifo_empty, seq_active, overflow, ack_timeout_err;
    logic [7:0] phoneme_sel;
    logic [CW-1:0] fifo_count;
    int checks = 0, failures = 0;
    always #5 Clock = ~Clock;
    phoneme_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .Clock(Clock), .Reset_H(Reset_H), .push_valid(push_valid), .push_data(push_data),
        .flush(flush), .pause(pause), .clear_flags(clear_flags),
        .phoneme_speech_busy(phoneme_speech_busy), .phoneme_speech_finish(phoneme_speech_finish),
        .start_phoneme_output(start_phoneme_output), .phoneme_sel(phoneme_sel),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .seq_active(seq_active), .overflow(overflow), .ack_timeout_err(ack_timeout_err)
    );
    // Reference model: queue contents plus "phoneme in flight" bookkeeping measured in edges since pop.
    logic [7:0] mq[$];
    logic [7:0] m_sel;
    bit m_own, m_acked, m_ovf, m_err;
    int m_age, m_gap;
    // Engine model and observed start pulses.
    bit eng_on = 1'b1, rnd_eng = 1'b0;
    int e_cnt = 0, e_dly = 2, e_len = 20;
    logic [7:0] played[$];
    logic [CW-1:0] cnt_at_start[$];
    typedef struct {
        logic pv; logic [7:0] pd; logic fl, pa, cf, bz, fn;
        logic st; logic [7:0] sel; logic [CW-1:0] cnt; logic act;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [18:0] outs();
        return {start_phoneme_output, phoneme_sel, fifo_count, fifo_full, fifo_empty,
                seq_active, overflow, ack_timeout_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sel = 8'h00; m_own = 0; m_acked = 0; m_ovf = 0; m_err = 0; m_age = 0; m_gap = 0;
    endtask

    task automatic model_step(input logic pv, input logic [7:0] pd, input logic fl, pa, cf, bz, fn);
        bit full0, ended, tmo, ovf_set;
        full0 = mq.size() == DEPTH; ended = 0; tmo = 0; ovf_set = 0;
        if (!m_own) begin
            if (mq.size() != 0 && !pa && !fl) begin
                m_sel = mq.pop_front(); m_own = 1; m_age = 0; m_acked = 0; m_gap = 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_own = 0;
        end else begin
            if (m_age >= 1) begin
                if (!m_acked) begin
                    if (bz) m_acked = 1;
                    else if (m_age == ACK_TIMEOUT) begin tmo = 1; ended = 1; end
                end else if (fn || !bz) ended = 1;
            end
            m_age++;
            if (ended) begin
                if (GAPB) m_gap = GAP_CYCLES;
                else m_own = 0;
            end
        end
        if (fl) mq.delete();
        else if (pv) begin
            if (full0) ovf_set = 1;
            else mq.push_back(pd);
        end
        m_ovf = ovf_set || (m_ovf && !cf);
        m_err = tmo || (m_err && !cf);
    endtask

    task automatic tick(input logic pv, input logic [7:0] pd, input logic fl, pa, cf, bz, fn);
        push_valid = pv; push_data = pd; flush = fl; pause = pa; clear_flags = cf;
        phoneme_speech_busy = bz; phoneme_speech_finish = fn;
        model_step(pv, pd, fl, pa, cf, bz, fn);
        @(posedge Clock);
        @(negedge Clock);
        check("cycle", outs(), {m_own && m_gap == 0 && m_age == 1, m_sel, CW'(mq.size()),
                                mq.size() == DEPTH, mq.size() == 0, m_own, m_ovf, m_err});
        if (start_phoneme_output) begin
            played.push_back(phoneme_sel);
            cnt_at_start.push_back(fifo_count);
        end
    endtask

    task automatic etick(input logic pv, input logic [7:0] pd, input logic fl, pa, cf);
        if (start_phoneme_output) begin
            if (rnd_eng) begin
                eng_on = $urandom_range(0, 9) != 0;
                e_dly = $urandom_range(1, 4);
                e_len = $urandom_range(1, 8);
            end
            e_cnt = eng_on ? e_dly + e_len : 0;
        end else if (e_cnt > 0) e_cnt--;
        tick(pv, pd, fl, pa, cf, e_cnt > 0 && e_cnt <= e_len, e_cnt == 1);
    endtask

    task automatic run(input int n, input logic pa);
        for (int i = 0; i < n; i++) etick(1'b0, 8'h00, 1'b0, pa, 1'b0);
    endtask

    task automatic idle_inputs();
        push_valid = 0; push_data = 0; flush = 0; pause = 0; clear_flags = 0;
        phoneme_speech_busy = 0; phoneme_speech_finish = 0;
        e_cnt = 0;
    endtask

    task automatic mid_reset(input string name);
        #2 Reset_H = 1'b1;
        #1 check(name, outs(), RST_OUT);
        idle_inputs();
        model_reset();
        @(negedge Clock);
        Reset_H = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] exp3[3];
        logic [CW-1:0] expc[3];
        exp3 = '{8'h05, 8'h10, 8'h2B};
        expc = '{CW'(2), CW'(1), CW'(0)};
        tbl[0] = '{1, 8'h1A, 0, 0, 0, 0, 0, 0, 8'h00, CW'(1), 0};
        tbl[1] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h1A, CW'(0), 1};
        tbl[2] = '{0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h1A, CW'(0), 1};
        tbl[3] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h1A, CW'(0), 1};
        tbl[4] = '{0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h1A, CW'(0), GAPB};
        tbl[5] = '{1, 8'h55, 0, 1, 0, 0, 0, 0, 8'h1A, CW'(1), GAPB};
        tbl[6] = '{0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h1A, CW'(1), GAPB};
        tbl[7] = '{1, 8'h66, 1, 0, 0, 0, 0, 0, 8'h1A, CW'(0), GAPB};
        tbl[8] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h1A, CW'(0), GAPB};

        model_reset();
        idle_inputs();
        Reset_H = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("reset", outs(), RST_OUT);
        Reset_H = 1'b0;

        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].pv, tbl[i].pd, tbl[i].fl, tbl[i].pa, tbl[i].cf, tbl[i].bz, tbl[i].fn);
            check($sformatf("vec%0d", i), {start_phoneme_output, phoneme_sel, fifo_count, seq_active},
                  {tbl[i].st, tbl[i].sel, tbl[i].cnt, tbl[i].act});
        end
        run(20, 0);

        // single phoneme: pulse 2 cycles after the push edge, one cycle wide
        played.delete();
        etick(1, 8'h1A, 0, 0, 0);
        n = -1;
        for (int k = 1; k <= 50; k++) begin
            etick(0, 8'h00, 0, 0, 0);
            if (start_phoneme_output && n < 0) n = k;
        end
        check("t1_latency", n, 2);
        check("t1_pulses", played.size(), 1);
        check("t1_sel", played.size() > 0 ? played[0] : 8'hxx, 8'h1A);
        check("t1_idle", seq_active, 0);

        // three back-to-back phonemes
        played.delete(); cnt_at_start.delete();
        etick(1, 8'h05, 0, 1, 0); etick(1, 8'h10, 0, 1, 0); etick(1, 8'h2B, 0, 1, 0);
        check("t2_count3", fifo_count, 3);
        run(160, 0);
        check("t2_pulses", played.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_sel%0d", i), i < played.size() ? played[i] : 8'hxx, exp3[i]);
            check($sformatf("t2_cnt%0d", i), i < cnt_at_start.size() ? cnt_at_start[i] : 'x, expc[i]);
        end

        // overflow with pause held
        played.delete();
        for (int i = 0; i < 17; i++) etick(1, 8'(8'h40 + i), 0, 1, 0);
        check("t3_full", fifo_full, 1);
        check("t3_count", fifo_count, DEPTH);
        check("t3_overflow", overflow, 1);
        etick(0, 8'h00, 0, 1, 1);
        check("t3_clear", overflow, 0);
        run(800, 0);
        check("t3_pulses", played.size(), 16);
        check("t3_last", played.size() > 0 ? played[played.size()-1] : 8'hxx, 8'h4F);

        // engine never acknowledges
        played.delete();
        eng_on = 0;
        etick(1, 8'h21, 0, 0, 0); etick(1, 8'h22, 0, 0, 0);
        n = 0;
        while (!start_phoneme_output && n < 10) begin etick(0, 8'h00, 0, 0, 0); n++; end
        n = 0;
        while (!ack_timeout_err && n < 4 * ACK_TIMEOUT) begin etick(0, 8'h00, 0, 0, 0); n++; end
        check("t4_timeout", n, ACK_TIMEOUT);
        eng_on = 1;
        n = 0;
        while (!start_phoneme_output && n < 40) begin etick(0, 8'h00, 0, 0, 0); n++; end
        check("t4_next_launch", n, 2 + (GAPB ? GAP_CYCLES : 0));
        run(60, 0);
        check("t4_sel", played.size() > 1 ? played[1] : 8'hxx, 8'h22);
        etick(0, 8'h00, 0, 0, 1);
        check("t4_clear", ack_timeout_err, 0);

        // flush while the first of four plays
        played.delete();
        for (int i = 0; i < 4; i++) etick(1, 8'(8'h31 + i), 0, 1, 0);
        n = 0;
        while (!phoneme_speech_busy && n < 20) begin etick(0, 8'h00, 0, 0, 0); n++; end
        run(2, 0);
        etick(0, 8'h00, 1, 0, 0);
        check("t5_count", fifo_count, 0);
        check("t5_active", seq_active, 1);
        run(60, 0);
        check("t5_pulses", played.size(), 1);
        check("t5_idle", seq_active, 0);

`ifdef PHONEME_GAP_EN
        // finish-to-start spacing, then reset in the middle of the gap
        played.delete();
        etick(1, 8'h61, 0, 1, 0); etick(1, 8'h62, 0, 1, 0);
        n = 0;
        do begin etick(0, 8'h00, 0, 0, 0); n++; end while (!phoneme_speech_finish && n < 100);
        n = 0;
        while (!start_phoneme_output && n < 40) begin etick(0, 8'h00, 0, 0, 0); n++; end
        check("gap_spacing", n, GAP_CYCLES + 2);
        n = 0;
        do begin etick(0, 8'h00, 0, 0, 0); n++; end while (!phoneme_speech_finish && n < 100);
        run(3, 0);
        mid_reset("rst_mid_gap");
`endif
        // reset with a phoneme in flight
        etick(1, 8'h77, 0, 0, 0);
        n = 0;
        while (!phoneme_speech_busy && n < 20) begin etick(0, 8'h00, 0, 0, 0); n++; end
        run(2, 0);
        mid_reset("rst_mid_phoneme");
        played.delete();
        run(30, 0);
        check("rst_no_retrigger", played.size(), 0);

        // randomized traffic against the model
        rnd_eng = 1;
        for (int i = 0; i < 4000; i++)
            etick($urandom_range(0, 99) < 35, 8'($urandom), $urandom_range(0, 99) < 2,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
